// File: rtl/reg_incr_pipe.sv
// reg_incr_pipe -- elastic valid/ready pipeline that adds `step` to the
// operand in every stage, so a message leaves with in_msg + nstages*step.
//
// Parameters
//   nbits   : data width (1..64)
//   nstages : number of register stages (1..8)
//   step    : amount added per stage
//   sat     : 0 = wrap modulo 2^nbits, 1 = clamp to all-ones
// Ports
//   clk, reset (async, active low)
//   in_val/in_rdy/in_msg            : input handshake and operand
//   out_val/out_rdy/out_msg/out_ovf : output handshake, result, overflow flag
//   count                           : completed output transfers, mod 2^16
//
// Position 0 of the *_pipe vectors is the input port; position k+1 is the
// register of stage k, so the last entry is what the output port sees.

// One pipeline stage: holds val/data/ovf, loads din+step when its
// predecessor hands a message over, empties when its own message leaves.
module reg_incr_stage #(
  parameter int               nbits = 8,
  parameter logic [nbits-1:0] step  = nbits'(1),
  parameter bit               sat   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [nbits-1:0] din,
  input  logic             ovf_in,
  output logic             vld,
  output logic [nbits-1:0] data,
  output logic             ovf
);
  logic [nbits:0] sum;

  assign sum = {1'b0, din} + {1'b0, step};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld  <= 1'b0;
      data <= '0;
      ovf  <= 1'b0;
    end else if (load) begin
      // load wins over drain: a stage emptied and refilled on the same edge
      // stays valid. A saturated value is all-ones, so any later carry
      // clamps it again and it stays all-ones down the pipe.
      vld  <= 1'b1;
      data <= (sat && sum[nbits]) ? '1 : sum[nbits-1:0];
      ovf  <= ovf_in | sum[nbits];
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end
endmodule

module reg_incr_pipe #(
  parameter int               nbits   = 8,
  parameter int               nstages = 2,
  parameter logic [nbits-1:0] step    = nbits'(1),
  parameter bit               sat     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_msg,
  output logic             out_ovf,
  output logic [15:0]      count
);
  logic [nstages:0]            vld_pipe;
  logic [nstages:0][nbits-1:0] data_pipe;
  logic [nstages:0]            ovf_pipe;
  // go[k]: the message at position k moves on at the next edge
  logic [nstages:0]            go;

  assign vld_pipe[0]  = in_val;
  assign data_pipe[0] = in_msg;
  assign ovf_pipe[0]  = 1'b0;

  // Ready ripples backwards from the output: a position moves when the next
  // one is empty or moving itself. Empty stages are always refilled, which
  // collapses bubbles even while the output is stalled.
  always_comb begin
    go = '0;
    go[nstages] = vld_pipe[nstages] & out_rdy;
    for (int k = nstages - 1; k >= 0; k--)
      go[k] = vld_pipe[k] & (~vld_pipe[k+1] | go[k+1]);
  end

  // Held low during reset so nothing is offered while the pipe is cleared.
  assign in_rdy = reset & (~vld_pipe[1] | go[1]);

  for (genvar k = 0; k < nstages; k++) begin : g_stage
    reg_incr_stage #(
      .nbits (nbits),
      .step  (step),
      .sat   (sat)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .load   (go[k]),
      .drain  (go[k+1]),
      .din    (data_pipe[k]),
      .ovf_in (ovf_pipe[k]),
      .vld    (vld_pipe[k+1]),
      .data   (data_pipe[k+1]),
      .ovf    (ovf_pipe[k+1])
    );
  end

  assign out_val = vld_pipe[nstages];
  assign out_msg = data_pipe[nstages];
  assign out_ovf = ovf_pipe[nstages];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            count <= '0;
    else if (go[nstages])  count <= count + 16'd1;
  end
endmodule

// File: tb/tb_reg_incr_pipe.sv
// Bench for reg_incr_pipe: four instances (wrap, saturate, 16-bit x1 stage,
// 16-bit x4 stages) on a shared clock/reset. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Latency below is
// counted in cycles from the cycle in which in_val is presented.
module tb_reg_incr_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic a_iv = 0, a_ir, a_ordy = 0, a_ov, a_oo;
  logic [7:0] a_im = 0, a_om;
  logic [15:0] a_cnt;
  logic s_iv = 0, s_ir, s_ordy = 1, s_ov, s_oo;
  logic [7:0] s_im = 0, s_om;
  logic [15:0] s_cnt;
  logic p1_iv = 0, p1_ir, p1_ordy = 1, p1_ov, p1_oo;
  logic [15:0] p1_im = 0, p1_om, p1_cnt;
  logic p4_iv = 0, p4_ir, p4_ordy = 1, p4_ov, p4_oo;
  logic [15:0] p4_im = 0, p4_om, p4_cnt;

  logic [63:0] qa[$], qs[$], q1[$], q4[$];

  reg_incr_pipe #(.nbits(8), .nstages(2), .step(8'd1), .sat(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_val(a_iv), .in_rdy(a_ir), .in_msg(a_im),
    .out_val(a_ov), .out_rdy(a_ordy), .out_msg(a_om), .out_ovf(a_oo), .count(a_cnt));
  reg_incr_pipe #(.nbits(8), .nstages(2), .step(8'd1), .sat(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_val(s_iv), .in_rdy(s_ir), .in_msg(s_im),
    .out_val(s_ov), .out_rdy(s_ordy), .out_msg(s_om), .out_ovf(s_oo), .count(s_cnt));
  reg_incr_pipe #(.nbits(16), .nstages(1), .step(16'd3), .sat(1'b0)) dut_p1 (
    .clk(clk), .reset(reset), .in_val(p1_iv), .in_rdy(p1_ir), .in_msg(p1_im),
    .out_val(p1_ov), .out_rdy(p1_ordy), .out_msg(p1_om), .out_ovf(p1_oo), .count(p1_cnt));
  reg_incr_pipe #(.nbits(16), .nstages(4), .step(16'd3), .sat(1'b0)) dut_p4 (
    .clk(clk), .reset(reset), .in_val(p4_iv), .in_rdy(p4_ir), .in_msg(p4_im),
    .out_val(p4_ov), .out_rdy(p4_ordy), .out_msg(p4_om), .out_ovf(p4_oo), .count(p4_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, msg} for d + ns*st under wrap or saturate.
  function automatic logic [63:0] model(input logic [63:0] d, input int nb,
                                        input int ns, input int st, input bit s);
    logic [63:0] mx, sum, r;
    logic o;
    mx  = (64'd1 << nb) - 64'd1;
    sum = d + 64'(ns * st);
    o   = sum > mx;
    r   = o ? (s ? mx : (sum & mx)) : sum;
    return (64'(o) << nb) | r;
  endfunction

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboards: push the expected result when an input transfer is seen,
  // pop and compare when an output transfer is seen.
  always @(negedge clk) if (reset) begin
    if (a_ov && a_ordy) begin
      chk("a_order", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) chk("a_out", {a_oo, a_om}, qa.pop_front());
    end
    if (a_iv && a_ir) qa.push_back(model(64'(a_im), 8, 2, 1, 1'b0));
  end
  always @(negedge clk) if (reset) begin
    if (s_ov && s_ordy) begin
      chk("s_order", 64'(qs.size() != 0), 64'd1);
      if (qs.size() != 0) chk("s_out", {s_oo, s_om}, qs.pop_front());
    end
    if (s_iv && s_ir) qs.push_back(model(64'(s_im), 8, 2, 1, 1'b1));
  end
  always @(negedge clk) if (reset) begin
    if (p1_ov && p1_ordy) begin
      chk("p1_order", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) chk("p1_out", {p1_oo, p1_om}, q1.pop_front());
    end
    if (p1_iv && p1_ir) q1.push_back(model(64'(p1_im), 16, 1, 3, 1'b0));
  end
  always @(negedge clk) if (reset) begin
    if (p4_ov && p4_ordy) begin
      chk("p4_order", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) chk("p4_out", {p4_oo, p4_om}, q4.pop_front());
    end
    if (p4_iv && p4_ir) q4.push_back(model(64'(p4_im), 16, 4, 3, 1'b0));
  end

  initial begin
    logic [5:0] pat;
    int acc;

    // ---- reset state
    #1 reset = 1'b0;
    a_ordy = 1'b1;
    repeat (2) mid();
    #1;
    chk("rst_a_val", a_ov, 0);
    chk("rst_a_msg", a_om, 0);
    chk("rst_a_ovf", a_oo, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_rdy", a_ir, 0);
    chk("rst_s_rdy", s_ir, 0);
    chk("rst_p4_val", p4_ov, 0);
    mid();
    reset = 1'b1;

    // ---- single message, latency 2
    nx(); a_iv = 1; a_im = 8'h05; mid();
    chk("rdy_after_rst", a_ir, 1);
    chk("single_c0", a_ov, 0);
    nx(); a_iv = 0; mid();
    chk("single_c1", a_ov, 0);
    nx(); mid();
    chk("single_c2_val", a_ov, 1);
    chk("single_c2_msg", a_om, 8'h07);
    chk("single_c2_ovf", a_oo, 0);
    chk("single_c2_cnt", a_cnt, 0);
    nx(); mid();
    chk("single_c3_cnt", a_cnt, 1);
    chk("single_c3_val", a_ov, 0);

    // ---- overflow, wrap vs saturate
    nx(); a_iv = 1; a_im = 8'hFF; s_iv = 1; s_im = 8'hFF; mid();
    nx(); a_im = 8'hFD; s_im = 8'hFD; mid();
    nx(); a_iv = 0; s_iv = 0; mid();
    chk("wrap_ff_msg", a_om, 8'h01);
    chk("wrap_ff_ovf", a_oo, 1);
    chk("sat_ff_msg", s_om, 8'hFF);
    chk("sat_ff_ovf", s_oo, 1);
    nx(); mid();
    chk("wrap_fd_msg", a_om, 8'hFF);
    chk("wrap_fd_ovf", a_oo, 0);
    chk("sat_fd_msg", s_om, 8'hFF);
    chk("sat_fd_ovf", s_oo, 0);
    nx(); mid();
    chk("ovf_cnt", a_cnt, 3);

    // ---- backpressure: fills to 2, then drains one per cycle
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      nx(); a_ordy = 0; a_iv = 1; a_im = 8'(acc + 1); mid();
      chk("bp_rdy", a_ir, 64'(acc < 2));
      if (i >= 2) chk("bp_hold", a_om, 8'h03);
      if (a_ir) acc++;
    end
    for (int i = 0; i < 5; i++) begin
      nx(); a_ordy = 1; a_iv = (acc < 4); a_im = 8'(acc + 1); mid();
      chk("bp_val", a_ov, 64'(i < 4));
      if (i == 0) chk("bp_same_edge", a_ir, 1);
      if (a_iv && a_ir) acc++;
    end
    chk("bp_cnt", a_cnt, 7);

    // ---- bubbles: out_val repeats the in_val pattern 2 cycles later
    pat = 6'b101101;
    for (int i = 0; i < 9; i++) begin
      nx(); a_iv = (i < 6) ? pat[i] : 1'b0; a_im = 8'(8'h20 + i); mid();
      chk("bubble", a_ov, (i >= 2 && i < 8) ? 64'(pat[i-2]) : 64'd0);
    end
    chk("bubble_cnt", a_cnt, 11);

    // ---- random valid/ready against the scoreboard
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      nx();
      a_iv = 1'($urandom_range(0, 1));
      a_im = 8'($urandom);
      a_ordy = ($urandom_range(0, 3) != 0);
      mid();
      if (a_iv && a_ir) acc++;
    end
    nx(); a_iv = 0; a_ordy = 1;
    repeat (3) nx();
    mid();
    chk("rand_drain", 64'(qa.size()), 0);
    chk("rand_cnt", a_cnt, 64'(16'(11 + acc)));

    // ---- reset in the middle of traffic
    nx(); a_iv = 1; a_im = 8'h30; a_ordy = 0; mid();
    nx(); a_im = 8'h31; mid();
    nx(); a_iv = 0; mid();
    chk("pre_rst_val", a_ov, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_val", a_ov, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_msg", a_om, 0);
    chk("mid_rst_rdy", a_ir, 0);
    qa.delete();
    mid(); mid();
    reset = 1'b1;
    nx(); a_iv = 1; a_im = 8'h10; a_ordy = 1; mid();
    chk("post_rst_rdy", a_ir, 1);
    nx(); a_iv = 0; mid();
    chk("post_rst_c1", a_ov, 0);
    nx(); mid();
    chk("post_rst_val", a_ov, 1);
    chk("post_rst_msg", a_om, 8'h12);
    nx(); mid();
    chk("post_rst_cnt", a_cnt, 1);

    // ---- 16-bit, step 3, nstages 1 and 4
    nx(); p1_iv = 1; p4_iv = 1; p1_im = 16'h1234; p4_im = 16'h1234; mid();
    nx(); p1_im = 16'hFFFE; p4_im = 16'hFFFE; mid();
    chk("p1_lat_val", p1_ov, 1);
    chk("p1_lat_msg", p1_om, 16'h1237);
    chk("p4_c1", p4_ov, 0);
    nx(); p1_iv = 0; p4_iv = 0; mid();
    chk("p1_wrap_msg", p1_om, 16'h0001);
    chk("p1_wrap_ovf", p1_oo, 1);
    chk("p4_c2", p4_ov, 0);
    nx(); mid();
    chk("p4_c3", p4_ov, 0);
    nx(); mid();
    chk("p4_lat_val", p4_ov, 1);
    chk("p4_lat_msg", p4_om, 16'h1240);
    nx(); mid();
    chk("p4_wrap_msg", p4_om, 16'h000A);
    chk("p4_wrap_ovf", p4_oo, 1);
    nx(); mid();
    chk("p4_cnt", p4_cnt, 2);

    // ---- count wraps after 65536 output transfers (2 already done on p1)
    for (int i = 0; i < 65534; i++) begin
      nx(); p1_iv = 1; p1_im = 16'(i); mid();
    end
    nx(); p1_iv = 0; mid();
    chk("cnt_ffff", p1_cnt, 16'hFFFF);
    nx(); mid();
    chk("cnt_wrap", p1_cnt, 16'h0000);
    chk("p1_drain", 64'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
